// File: rtl/shift_seq_pkg.sv
// Shared definitions for the SR2 command sequencer: opcodes, command record,
// control-byte packing and issue-controller states.
package shift_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b111;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } issue_state_e;

  function automatic logic [7:0] pack_ctrl(input logic [4:0] shamt, input logic [2:0] op);
    return {shamt, op};
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return op inside {OP_NOP, OP_SLL, OP_SRL, OP_LOAD};
  endfunction

  // Only ops that change SR2 give back a result (and therefore need a credit slot).
  function automatic logic op_has_result(input logic [2:0] op);
    return op inside {OP_SLL, OP_SRL, OP_LOAD};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while
// empty are ignored. Read data is the current head (fall-through).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             full, do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/shift_cmd_seq.sv
// Command sequencer for SR2: FIFOs commands, issues one per cycle under result
// credit, captures q two edges later. Optional issue counter: SHIFT_SEQ_CNT_EN.
module shift_cmd_seq
  import shift_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_shamt,
  input  logic [31:0] cmd_data,
  output logic [7:0]  data,
  output logic [31:0] data_in,
  input  logic [31:0] q,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        err
`ifdef SHIFT_SEQ_CNT_EN
  ,
  output logic [15:0] issue_cnt
`endif
);
  localparam int STAGES = 1;
  localparam int CCW    = $clog2(CMD_DEPTH) + 1;
  localparam int RCW    = $clog2(RES_DEPTH) + 1;
  localparam logic [CCW-1:0] CMD_FULL = CMD_DEPTH[CCW-1:0];
  localparam logic [RCW:0]   RES_LIM  = RES_DEPTH[RCW:0];

  cmd_t           cmd_w, cmd_head;
  logic           cmd_empty, res_empty;
  logic [CCW-1:0] cmd_count;
  logic [RCW-1:0] res_count;
  logic [STAGES:0] vld_pipe;
  logic [RCW:0]   used_cred;
  logic           credit_ok, pop;
  issue_state_e   state_q, state_d;

  assign cmd_w     = '{op: cmd_op, shamt: cmd_shamt, data: cmd_data};
  assign cmd_ready = (cmd_count != CMD_FULL);

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .wdata (cmd_w),
    .pop   (pop),
    .rdata (cmd_head),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  // Results in flight plus results waiting must never exceed the queue depth.
  assign used_cred = {1'b0, res_count} + {{RCW{1'b0}}, vld_pipe[0]}
                   + {{RCW{1'b0}}, vld_pipe[1]};
  assign credit_ok = (used_cred < RES_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop = !cmd_empty && credit_ok;
        if (!cmd_empty) state_d = credit_ok ? S_RUN : S_STALL;
      end
      S_RUN: begin
        pop = !cmd_empty && credit_ok;
        if (cmd_empty)       state_d = S_IDLE;
        else if (!credit_ok) state_d = S_STALL;
      end
      S_STALL: begin
        pop = !cmd_empty && credit_ok;
        if (cmd_empty)      state_d = S_IDLE;
        else if (credit_ok) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control byte is a one-cycle pulse; data_in keeps the last value driven.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data     <= 8'h00;
      data_in  <= '0;
      vld_pipe <= '0;
      err      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], pop && op_has_result(cmd_head.op)};
      data     <= 8'h00;
      if (pop) begin
        if (op_has_result(cmd_head.op)) begin
          data    <= pack_ctrl(cmd_head.shamt, cmd_head.op);
          data_in <= cmd_head.data;
        end
        if (!op_is_legal(cmd_head.op)) err <= 1'b1;
      end
    end
  end

  sync_fifo #(.WIDTH(32), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[STAGES]),
    .wdata (q),
    .pop   (res_ready),
    .rdata (res_data),
    .empty (res_empty),
    .count (res_count)
  );

  assign res_valid = !res_empty;

`ifdef SHIFT_SEQ_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   issue_cnt <= '0;
    else if (pop && op_has_result(cmd_head.op)) issue_cnt <= issue_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Scoreboard bench for shift_cmd_seq driving a behavioural SR2; covers the
// optional issue counter when SHIFT_SEQ_CNT_EN is defined.
module tb_shift_cmd_seq;
  import shift_seq_pkg::*;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_shamt;
  logic [31:0] cmd_data;
  logic [7:0]  data;
  logic [31:0] data_in, q, res_data;
  logic        res_valid, res_ready, err;
`ifdef SHIFT_SEQ_CNT_EN
  logic [15:0] issue_cnt;
`endif

  shift_cmd_seq #(.CMD_DEPTH(4), .RES_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_shamt(cmd_shamt), .cmd_data(cmd_data),
    .data(data), .data_in(data_in), .q(q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .err(err)
`ifdef SHIFT_SEQ_CNT_EN
    , .issue_cnt(issue_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SR2
  logic [31:0] sr2_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) sr2_q <= '0;
    else case (data[2:0])
      3'b001:  sr2_q <= sr2_q << data[7:3];
      3'b011:  sr2_q <= sr2_q >> data[7:3];
      3'b111:  sr2_q <= data_in;
      default: ;
    endcase
  end
  assign q = sr2_q;

  int n_checks = 0, n_errs = 0, cyc = 0, rr_mode = 1;
  logic [31:0] exp_q[$];
  logic [31:0] model_v = '0;
  logic [7:0]  data_log[$];
  int          data_cyc[$], res_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: SR2 register value evolves in command order; every real op yields it.
  function automatic void model_accept(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] d);
    case (op)
      3'b111: begin model_v = d;              exp_q.push_back(model_v); end
      3'b001: begin model_v = model_v << sh;  exp_q.push_back(model_v); end
      3'b011: begin model_v = model_v >> sh;  exp_q.push_back(model_v); end
      default: ;
    endcase
  endfunction

  // Monitor: pops expected results on every handshake
  always @(negedge clk) begin
    if (rst) begin
      if (data != 8'h00) begin data_log.push_back(data); data_cyc.push_back(cyc); end
      if (res_valid && res_ready) begin
        res_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL unexpected_result: got %h expected none", res_data);
        end else check("result", res_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rr_mode == 0)      res_ready = 1'b0;
      else if (rr_mode == 1) res_ready = 1'b1;
      else                   res_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] d);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_shamt = sh; cmd_data = d;
    @(negedge clk);
    while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_checks++; n_errs++;
      $display("FAIL send_timeout: got cmd_ready=0 expected 1");
    end else model_accept(op, sh, d);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_logs();
    data_log.delete(); data_cyc.delete(); res_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_bytes [4];
  logic [7:0] got_b;
  logic [2:0] ops [6];
  logic [2:0] rop;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_shamt = '0; cmd_data = '0;
    exp_bytes = '{8'h07, 8'h09, 8'h31, 8'hC1};
    ops = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b001, 3'b011};
    repeat (3) @(posedge clk); #1;
    check("rst_data", data, 8'h00);
    check("rst_data_in", data_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_err", err, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1);

    // Back-to-back LOAD + shifts
    clear_logs();
    send(OP_LOAD, 5'd0, 32'h1);
    send(OP_SLL, 5'd1, 32'h0);
    send(OP_SLL, 5'd6, 32'h0);
    send(OP_SLL, 5'd24, 32'h0);
    idle(1); drain();
    check("b2b_data_cnt", data_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got_b = (i < data_log.size()) ? data_log[i] : 8'hxx;
      check("b2b_ctrl_byte", got_b, exp_bytes[i]);
    end
    check("b2b_issue_span", (data_cyc.size() >= 4) ? 32'(data_cyc[3] - data_cyc[0]) : 32'hFFFF_FFFF, 3);
    check("b2b_latency", (res_cyc.size() >= 1 && data_cyc.size() >= 1) ? 32'(res_cyc[0] - data_cyc[0]) : 32'hFFFF_FFFF, 2);
    check("b2b_res_span", (res_cyc.size() >= 4) ? 32'(res_cyc[3] - res_cyc[0]) : 32'hFFFF_FFFF, 3);
    check("b2b_idle_data", data, 8'h00);

    // LOAD then SRL
    clear_logs();
    send(OP_LOAD, 5'd0, 32'hFF0);
    send(OP_SRL, 5'd4, 32'h0);
    idle(1); drain();
    check("srl_res_cnt", res_cyc.size(), 2);

    // Backpressure: 8 shifts with res_ready low
    rr_mode = 0; @(posedge clk); #2;
    clear_logs();
    for (int i = 0; i < 8; i++) send(OP_SLL, 5'd1, $urandom);
    idle(1);
    repeat (20) @(negedge clk);
    check("stall_issued", data_log.size(), 4);
    check("stall_data", data, 8'h00);
    check("stall_res_valid", res_valid, 1);
    check("stall_cmd_ready", cmd_ready, 0);
    check("stall_no_deq", res_cyc.size(), 0);
    rr_mode = 1;
    drain();
    check("release_issued", data_log.size(), 8);
    check("release_res_cnt", res_cyc.size(), 8);

    // Illegal op
    clear_logs();
    send(3'b101, 5'd3, 32'h0);
    idle(1);
    repeat (6) @(negedge clk);
    check("ill_err", err, 1);
    check("ill_no_result", res_cyc.size(), 0);
    check("ill_no_issue", data_log.size(), 0);
    send(OP_LOAD, 5'd0, 32'hABCD_1234);
    idle(1); drain();
    check("ill_err_sticky", err, 1);
    check("ill_load_res", res_cyc.size(), 1);

    // Randomized traffic with random backpressure
    rr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      rop = ($urandom_range(0, 15) == 0) ? 3'b010 : ops[$urandom_range(0, 5)];
      send(rop, 5'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    rr_mode = 1;
    drain();
    check("rand_idle_data", data, 8'h00);

    // Fill FIFO under stall, then reset mid-stream
    rr_mode = 0; @(posedge clk); #2;
    for (int i = 0; i < 8; i++) send(OP_SLL, 5'd2, 32'hDEAD_0000 | 32'(i));
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_data_in_live", data_in, 32'hDEAD_0003);
    #2 rst = 1'b0;
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_data_in", data_in, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_err", err, 0);
    exp_q.delete(); model_v = '0;
    cmd_valid = 1'b0; rr_mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    repeat (6) @(negedge clk);
    check("post_rst_res_valid", res_valid, 0);
    check("post_rst_data", data, 8'h00);

`ifdef SHIFT_SEQ_CNT_EN
    send(OP_SLL, 5'd1, 32'h0);
    send(OP_SRL, 5'd1, 32'h0);
    send(OP_SLL, 5'd3, 32'h0);
    send(OP_NOP, 5'd0, 32'h0);
    idle(1); drain();
    check("issue_cnt", issue_cnt, 3);
`endif

    send(OP_LOAD, 5'd0, 32'h5A5A_A5A5);
    idle(1); drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
